// File: rtl/sm_clk_ctrl.sv
// sm_clk_ctrl: CPU clock-enable controller with free-run, single-step and breakpoint.
// Ports: clkIn/rst (sync, active high), run, stepBtn, devide[3:0], bpEnable,
//        bpAddr[31:0], pc[31:0] -> cpuEn, halted, bpHit, instrCount[31:0].
module sm_clk_ctrl #(
    parameter int SHIFT = 16,
    parameter int CNT_W = 32
) (
    input  logic        clkIn,
    input  logic        rst,
    input  logic        run,
    input  logic        stepBtn,
    input  logic [3:0]  devide,
    input  logic        bpEnable,
    input  logic [31:0] bpAddr,
    input  logic [31:0] pc,
    output logic        cpuEn,
    output logic        halted,
    output logic        bpHit,
    output logic [31:0] instrCount
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BREAK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cpu_en_q, cpu_en_d;
    logic              halted_q, halted_d;
    logic              bp_hit_q, bp_hit_d;
    logic [31:0]       instr_cnt_q, instr_cnt_d;
    logic              step_prev_q, step_prev_d;

    logic [5:0]        sh;
    logic [CNT_W-1:0]  limit;
    logic              tick_due;
    logic              bp_match;
    logic              step_edge;

    // Limit follows devide live; >= lets a lowered rate fire at once.
    always_comb begin
        sh        = 6'(SHIFT) + {2'b00, devide};
        limit     = (ONE << sh) - ONE;
        tick_due  = (cnt_q >= limit);
        bp_match  = bpEnable && (pc == bpAddr);
        step_edge = stepBtn && !step_prev_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cpu_en_d    = 1'b0;
        step_prev_d = stepBtn;
        instr_cnt_d = instr_cnt_q + {31'd0, cpu_en_q};
        unique case (state_q)
            ST_HALT: begin
                // run has priority over a simultaneous step edge
                if (run) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (step_edge) begin
                    cpu_en_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    state_d = ST_HALT;
                    cnt_d   = '0;
                end else if (tick_due) begin
                    cnt_d = '0;
                    if (bp_match) begin
                        state_d = ST_BREAK;
                    end else begin
                        cpu_en_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_BREAK: begin
                if (!run) begin
                    state_d = ST_HALT;
                end
                // stepping out of a breakpoint ignores the match
                if (step_edge) begin
                    cpu_en_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_HALT;
                cnt_d   = '0;
            end
        endcase
        halted_d = (state_d != ST_RUN);
        bp_hit_d = (state_d == ST_BREAK);
    end

    always_ff @(posedge clkIn) begin
        if (rst) begin
            state_q     <= ST_HALT;
            cnt_q       <= '0;
            cpu_en_q    <= 1'b0;
            halted_q    <= 1'b1;
            bp_hit_q    <= 1'b0;
            instr_cnt_q <= '0;
            // a button held through reset must not count as a press
            step_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cpu_en_q    <= cpu_en_d;
            halted_q    <= halted_d;
            bp_hit_q    <= bp_hit_d;
            instr_cnt_q <= instr_cnt_d;
            step_prev_q <= step_prev_d;
        end
    end

    assign cpuEn      = cpu_en_q;
    assign halted     = halted_q;
    assign bpHit      = bp_hit_q;
    assign instrCount = instr_cnt_q;

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// tb_sm_clk_ctrl: directed bench for sm_clk_ctrl (SHIFT=2).
// Expected pulses (cycle, instrCount) are queued; a monitor pops on cpuEn.
module tb_sm_clk_ctrl;

    logic        clk = 1'b0;
    logic        rst, run, stepBtn, bpEnable;
    logic [3:0]  devide;
    logic [31:0] bpAddr, pc;
    logic        cpuEn, halted, bpHit;
    logic [31:0] instrCount;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit done = 1'b0;

    typedef struct {
        int          c;
        logic [31:0] n;
    } exp_t;
    exp_t exp_q[$];

    sm_clk_ctrl #(.SHIFT(2), .CNT_W(32)) dut (
        .clkIn(clk), .rst(rst), .run(run), .stepBtn(stepBtn),
        .devide(devide), .bpEnable(bpEnable), .bpAddr(bpAddr), .pc(pc),
        .cpuEn(cpuEn), .halted(halted), .bpHit(bpHit),
        .instrCount(instrCount)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cpuEn must match the head of the queue; overdue heads are misses.
    always @(negedge clk) begin
        if (!done) begin
            while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_pulse: expected cpuEn at cyc %0d, absent (now %0d)",
                         exp_q[0].c, cyc);
                void'(exp_q.pop_front());
            end
            if (cpuEn) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse: cpuEn=1 at cyc %0d, required no pulse", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.c != cyc || instrCount !== e.n) begin
                        failures++;
                        $display("FAIL pulse: got cyc %0d count %0d, required cyc %0d count %0d",
                                 cyc, instrCount, e.c, e.n);
                    end
                end
            end
        end
    end

    task automatic push(input int c, input logic [31:0] n);
        exp_t e;
        e.c = c;
        e.n = n;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic upto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    int t;

    initial begin
        rst = 1'b1; run = 1'b0; stepBtn = 1'b0; devide = 4'd0;
        bpEnable = 1'b0; bpAddr = 32'd0; pc = 32'd0;
        step(3);
        chk("rst_cpuEn", {31'd0, cpuEn}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd1);
        chk("rst_bpHit", {31'd0, bpHit}, 32'd0);
        chk("rst_count", instrCount, 32'd0);
        rst = 1'b0;
        step(1);

        // free run, limit 3: pulses at +5, +9, +13
        t = cyc;
        run = 1'b1;
        push(t + 5, 0); push(t + 9, 1); push(t + 13, 2);
        step(1);
        chk("run_halted", {31'd0, halted}, 32'd0);
        upto(t + 14);
        chk("run_count", instrCount, 32'd3);
        run = 1'b0;
        step(2);
        chk("stop_halted", {31'd0, halted}, 32'd1);

        // limit 15, then devide drops to 0 while cnt=10
        devide = 4'd2;
        t = cyc;
        run = 1'b1;
        upto(t + 11);
        devide = 4'd0;
        push(t + 12, 3); push(t + 16, 4); push(t + 20, 5);
        upto(t + 20);
        run = 1'b0;
        step(2);
        chk("div_count", instrCount, 32'd6);

        // breakpoint at 0x8 after the second pulse
        rst = 1'b1;
        step(1);
        chk("rst2_count", instrCount, 32'd0);
        rst = 1'b0;
        bpEnable = 1'b1; bpAddr = 32'h8; pc = 32'h0; devide = 4'd0;
        step(1);
        t = cyc;
        run = 1'b1;
        push(t + 5, 0); push(t + 9, 1);
        upto(t + 9);
        pc = 32'h8;
        upto(t + 13);
        chk("bp_bpHit", {31'd0, bpHit}, 32'd1);
        chk("bp_halted", {31'd0, halted}, 32'd1);
        chk("bp_count", instrCount, 32'd2);
        step(6);
        chk("bp_stay", {31'd0, bpHit}, 32'd1);
        chk("bp_count2", instrCount, 32'd2);

        // held step in BREAK: one pulse only
        t = cyc;
        stepBtn = 1'b1;
        push(t + 1, 2);
        step(10);
        stepBtn = 1'b0;
        chk("brk_step_bpHit", {31'd0, bpHit}, 32'd1);
        chk("brk_step_count", instrCount, 32'd3);
        run = 1'b0;
        step(1);
        chk("brk_halt_bpHit", {31'd0, bpHit}, 32'd0);
        chk("brk_halt_halted", {31'd0, halted}, 32'd1);

        // step held through reset release: no pulse
        bpEnable = 1'b0; pc = 32'h0;
        stepBtn = 1'b1;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(3);
        chk("held_count", instrCount, 32'd0);
        stepBtn = 1'b0;
        step(1);
        t = cyc;
        stepBtn = 1'b1;
        push(t + 1, 0);
        step(2);
        stepBtn = 1'b0;
        step(2);
        chk("repress_count", instrCount, 32'd1);

        // run and step edge together: RUN, no step pulse
        t = cyc;
        run = 1'b1;
        stepBtn = 1'b1;
        step(1);
        chk("runstep_halted", {31'd0, halted}, 32'd0);
        chk("runstep_cpuEn", {31'd0, cpuEn}, 32'd0);

        // reset with cnt=limit cancels the pending pulse
        upto(t + 4);
        rst = 1'b1; run = 1'b0; stepBtn = 1'b0;
        step(1);
        rst = 1'b0;
        chk("rstrun_cpuEn", {31'd0, cpuEn}, 32'd0);
        chk("rstrun_halted", {31'd0, halted}, 32'd1);
        chk("rstrun_bpHit", {31'd0, bpHit}, 32'd0);
        chk("rstrun_count", instrCount, 32'd0);
        step(3);

        done = 1'b1;
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sm_clk_ctrl.md
SM_CLK_CTRL -- requirements
Module: sm_clk_ctrl

Interface
REQ-001 The block SHALL have parameter SHIFT, default 16, giving the base prescaler exponent; legal range 1..17.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the prescaler counter width; CNT_W SHALL be at least SHIFT+15.
REQ-003 The block SHALL have port clkIn, input, 1 bit: the single board clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port run, input, 1 bit: level request for free-run mode, already synchronized.
REQ-006 The block SHALL have port stepBtn, input, 1 bit: single-step button, already synchronized.
REQ-007 The block SHALL have port devide, input, 4 bits: rate select, where 0 is fastest.
REQ-008 The block SHALL have port bpEnable, input, 1 bit: breakpoint enable.
REQ-009 The block SHALL have port bpAddr, input, 32 bits: breakpoint instruction address.
REQ-010 The block SHALL have port pc, input, 32 bits: current CPU instruction address.
REQ-011 The block SHALL have port cpuEn, output, 1 bit: one-cycle CPU advance strobe.
REQ-012 The block SHALL have port halted, output, 1 bit: high whenever the state is not RUN.
REQ-013 The block SHALL have port bpHit, output, 1 bit: high in state BREAK.
REQ-014 The block SHALL have port instrCount, output, 32 bits: count of issued cpuEn pulses.

Function
REQ-015 The block SHALL implement states HALT, RUN and BREAK, encoded as a registered FSM.
REQ-016 The limit SHALL be 2^(SHIFT+devide)-1, computed at CNT_W bits from the current devide value.
REQ-017 In RUN, the prescaler cnt SHALL increment each cycle; when cnt >= limit, a tick is due and cnt SHALL load 0 next cycle.
REQ-018 Using >= SHALL ensure that lowering devide mid-count yields a tick on the next cycle, with no counter wrap-around wait.
REQ-019 In RUN with a tick due and not (bpEnable and pc == bpAddr), cpuEn SHALL be 1 in the following cycle, for exactly one cycle.
REQ-020 In RUN with a tick due and bpEnable and pc == bpAddr, the block SHALL issue no pulse, SHALL enter BREAK, and SHALL clear cnt.
REQ-021 HALT with run=1 SHALL move to RUN with cnt=0; the first pulse SHALL come limit+1 cycles later, subject to REQ-020.
REQ-022 RUN with run=0 SHALL move to HALT and clear cnt; run=0 SHALL win over a tick due in the same cycle, so no pulse is issued.
REQ-023 BREAK with run=0 SHALL move to HALT; BREAK SHALL NOT return to RUN while run stays 1.
REQ-024 The block SHALL detect a step edge as stepBtn=1 with previous stepBtn=0 (registered).
REQ-025 In HALT or BREAK, a step edge SHALL give cpuEn=1 for one cycle in the next cycle, ignore the breakpoint, and leave the state unchanged.
REQ-026 A held stepBtn SHALL produce no further pulses until it is released and pressed again.
REQ-027 Step edges in RUN SHALL be ignored.
REQ-028 When HALT sees run=1 and a step edge in the same cycle, run SHALL win: the state goes to RUN and no step pulse is issued.
REQ-029 instrCount SHALL increment by 1 on every cycle cpuEn=1, wrap from 0xFFFFFFFF to 0, and be cleared only by rst.
REQ-030 cpuEn SHALL be registered, never high in two consecutive cycles in step mode, and spaced at least limit+1 cycles apart in RUN.
REQ-031 halted and bpHit SHALL be registered decodes of the state.

Reset
REQ-032 On rst=1 at a clock edge, the block SHALL set state=HALT, cnt=0, cpuEn=0, halted=1, bpHit=0 and instrCount=0.
REQ-033 On rst=1, the previous-stepBtn register SHALL be set to 1, so a button held through reset gives no pulse.
REQ-034 rst SHALL override all other inputs in the same cycle, including mid-count and pending pulse, and SHALL cancel any pulse scheduled for the next cycle.

Verification (SHIFT=2)
REQ-035 Reset, then run=1 with devide=0 -> halted falls the next cycle; cpuEn pulses on cycles 5, 9, 13 after run rises (period 4); instrCount reaches 3.
REQ-036 devide=2 in RUN (limit 15), then devide changed to 0 when cnt=10 -> cpuEn the next-plus-one cycle; subsequent period 4.
REQ-037 bpEnable=1, bpAddr=0x0000_0008, pc driven to 0x8 after the second pulse -> no third pulse; bpHit=1 and halted=1; instrCount stays 2.
REQ-038 In BREAK, a stepBtn pulse held for 10 cycles -> exactly one cpuEn, state remains BREAK, instrCount=3; then run=0 -> HALT with bpHit=0.
REQ-039 HALT with stepBtn held high through reset release -> no cpuEn; after release and re-press -> one cpuEn; run=1 and step edge in the same cycle -> RUN entered with no immediate pulse.
REQ-040 rst asserted for one cycle in RUN with cnt=limit -> no cpuEn the next cycle; all outputs at reset values; instrCount=0.
